// File: rtl/csi_rx_hs_byte_align.sv
// csi_rx_hs_byte_align: per-lane D-PHY HS byte aligner (sync hunt over 8 bit offsets, lock, realign).
// Optional feature macro CSI_ALIGN_SOT_ERR_TOL_EN: 1-bit-error sync tolerance plus a sync_err output.
module csi_rx_hs_byte_align #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
  parameter int unsigned HUNT_TIMEOUT = 1024
) (
  input  logic       byte_clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       wait_for_sync,
  input  logic       packet_done,
  input  logic [7:0] deser_in,
  // data_out/data_vld is a valid-only stream: one byte transfers on every edge with data_vld high,
  // there is no ready, so the consumer must accept every valid byte.
  output logic [7:0] data_out,
  output logic       data_vld,
  output logic       sync_found,
  output logic [2:0] sync_offset,
  output logic       sync_timeout,
`ifdef CSI_ALIGN_SOT_ERR_TOL_EN
  output logic       sync_err,
`endif
  output logic [1:0] state_dbg
);

  localparam int CNT_W = (HUNT_TIMEOUT > 2) ? $clog2(HUNT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HUNT_TIMEOUT == 0) ? 0 : HUNT_TIMEOUT - 1);

  // state_dbg encoding: 0 = IDLE, 1 = HUNT, 2 = LOCKED
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       d0_q, d0_d;
  logic [7:0]       d1_q, d1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_vld_q, data_vld_d;
  logic             sync_found_q, sync_found_d;
  logic [2:0]       sync_offset_q, sync_offset_d;
  logic             sync_timeout_q, sync_timeout_d;
`ifdef CSI_ALIGN_SOT_ERR_TOL_EN
  logic             sync_err_q, sync_err_d;
  logic             near_hit;
  logic [2:0]       near_k;
  logic [7:0]       diff;
`endif

  logic [15:0] win;
  logic [7:0]  cand;
  logic        exact_hit, lock_hit;
  logic [2:0]  exact_k, lock_k;

  // d1 is the older byte, so the earliest wire bit sits at win[0]
  always_comb begin
    win       = {d0_q, d1_q};
    cand      = 8'h00;
    exact_hit = 1'b0;
    exact_k   = 3'd0;
`ifdef CSI_ALIGN_SOT_ERR_TOL_EN
    near_hit  = 1'b0;
    near_k    = 3'd0;
    diff      = 8'h00;
`endif
    for (int k = 0; k < 8; k++) begin
      cand = win[k +: 8];
      if (!exact_hit && (cand == SYNC_BYTE)) begin
        exact_hit = 1'b1;
        exact_k   = 3'(k);
      end
`ifdef CSI_ALIGN_SOT_ERR_TOL_EN
      diff = cand ^ SYNC_BYTE;
      if (!near_hit && $onehot(diff)) begin
        near_hit = 1'b1;
        near_k   = 3'(k);
      end
`endif
    end
`ifdef CSI_ALIGN_SOT_ERR_TOL_EN
    lock_hit = exact_hit | near_hit;
    lock_k   = exact_hit ? exact_k : near_k;
`else
    lock_hit = exact_hit;
    lock_k   = exact_k;
`endif
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    d0_d           = deser_in;
    d1_d           = d0_q;
    data_out_d     = data_out_q;
    data_vld_d     = 1'b0;
    sync_found_d   = 1'b0;
    sync_offset_d  = sync_offset_q;
    sync_timeout_d = 1'b0;
`ifdef CSI_ALIGN_SOT_ERR_TOL_EN
    sync_err_d     = 1'b0;
`endif
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (wait_for_sync) state_d = ST_HUNT;
        end
        ST_HUNT: begin
          // a match on the expiry cycle still locks
          if (lock_hit) begin
            state_d       = ST_LOCKED;
            sync_offset_d = lock_k;
            sync_found_d  = 1'b1;
            cnt_d         = '0;
`ifdef CSI_ALIGN_SOT_ERR_TOL_EN
            sync_err_d    = !exact_hit;
`endif
          end else if ((HUNT_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            state_d        = ST_IDLE;
            sync_timeout_d = 1'b1;
            cnt_d          = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (packet_done) begin
            state_d = wait_for_sync ? ST_HUNT : ST_IDLE;
            cnt_d   = '0;
          end else begin
            data_out_d = win[sync_offset_q +: 8];
            data_vld_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge byte_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      d0_q           <= 8'h00;
      d1_q           <= 8'h00;
      cnt_q          <= '0;
      data_out_q     <= 8'h00;
      data_vld_q     <= 1'b0;
      sync_found_q   <= 1'b0;
      sync_offset_q  <= 3'd0;
      sync_timeout_q <= 1'b0;
`ifdef CSI_ALIGN_SOT_ERR_TOL_EN
      sync_err_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      d0_q           <= d0_d;
      d1_q           <= d1_d;
      cnt_q          <= cnt_d;
      data_out_q     <= data_out_d;
      data_vld_q     <= data_vld_d;
      sync_found_q   <= sync_found_d;
      sync_offset_q  <= sync_offset_d;
      sync_timeout_q <= sync_timeout_d;
`ifdef CSI_ALIGN_SOT_ERR_TOL_EN
      sync_err_q     <= sync_err_d;
`endif
    end
  end

  assign data_out     = data_out_q;
  assign data_vld     = data_vld_q;
  assign sync_found   = sync_found_q;
  assign sync_offset  = sync_offset_q;
  assign sync_timeout = sync_timeout_q;
  assign state_dbg    = state_q;
`ifdef CSI_ALIGN_SOT_ERR_TOL_EN
  assign sync_err     = sync_err_q;
`endif

endmodule

// File: tb/tb_csi_rx_hs_byte_align.sv
// Bench for csi_rx_hs_byte_align: bit-level stream builder, first-occurrence sync model, scoreboard.
module tb_csi_rx_hs_byte_align;

  localparam logic [7:0] SYNC     = 8'hB8;
  localparam int         TIMEOUT  = 16;
  localparam logic [1:0] DBG_IDLE = 2'd0;
  localparam logic [1:0] DBG_HUNT = 2'd1;
`ifdef CSI_ALIGN_SOT_ERR_TOL_EN
  localparam bit TOL = 1'b1;
`else
  localparam bit TOL = 1'b0;
`endif

  // clock / reset
  logic       byte_clock = 1'b0;
  logic       reset_n, enable, wait_for_sync, packet_done;
  logic [7:0] deser_in;
  logic [7:0] data_out;
  logic       data_vld, sync_found, sync_timeout;
  logic [2:0] sync_offset;
  logic [1:0] state_dbg;
`ifdef CSI_ALIGN_SOT_ERR_TOL_EN
  logic       sync_err;
`endif

  always #5 byte_clock = ~byte_clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  csi_rx_hs_byte_align #(.SYNC_BYTE(SYNC), .HUNT_TIMEOUT(TIMEOUT)) dut (
    .byte_clock   (byte_clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .wait_for_sync(wait_for_sync),
    .packet_done  (packet_done),
    .deser_in     (deser_in),
    .data_out     (data_out),
    .data_vld     (data_vld),
    .sync_found   (sync_found),
    .sync_offset  (sync_offset),
    .sync_timeout (sync_timeout),
`ifdef CSI_ALIGN_SOT_ERR_TOL_EN
    .sync_err     (sync_err),
`endif
    .state_dbg    (state_dbg)
  );

  // scoreboard state
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         bits_q[$];
  logic [7:0] drive_q[$];
  logic [7:0] exp_q[$];
  int         exp_off;
  bit         exp_err;
  bit         exp_hit;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // stream builder: bits are pushed in wire order (earliest first)
  task automatic push_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) bits_q.push_back(v[i]);
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) bits_q.push_back(1'b0);
  endtask

  // reference model: scan the bit stream window by window; within a window
  // an exact sync at any offset beats a 1-bit match, lowest offset first
  task automatic predict(input int n_rx);
    logic [7:0] s;
    logic [7:0] b;
    int best_p, near_p, p, d, nwin;
    s       = SYNC;
    exp_hit = 1'b0;
    exp_err = 1'b0;
    best_p  = 0;
    nwin    = bits_q.size() / 8;
    for (int n = 0; n < nwin && !exp_hit; n++) begin
      near_p = -1;
      for (int j = 0; j < 8; j++) begin
        p = 8 * n + j;
        if (p + 8 > bits_q.size()) break;
        d = 0;
        for (int i = 0; i < 8; i++) if (bits_q[p+i] != s[i]) d++;
        if (d == 0 && !exp_hit) begin
          exp_hit = 1'b1;
          best_p  = p;
        end
        if (TOL && d == 1 && near_p < 0) near_p = p;
      end
      if (!exp_hit && near_p >= 0) begin
        exp_hit = 1'b1;
        exp_err = 1'b1;
        best_p  = near_p;
      end
    end
    exp_off = best_p % 8;
    exp_q.delete();
    for (int k = 0; k < n_rx; k++) begin
      for (int i = 0; i < 8; i++) begin
        p    = best_p + 8 + 8 * k + i;
        b[i] = (p < bits_q.size()) ? bits_q[p] : 1'b0;
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic idle(input int n);
    wait_for_sync = 1'b0;
    repeat (n) begin
      @(posedge byte_clock); #1;
      deser_in = 8'h00;
    end
    @(negedge byte_clock);
  endtask

  // driver + monitor for one packet; mode 0: end to IDLE, 1: end and rearm, 2: leave locked
  task automatic run_packet(input int n_rx, input int mode);
    logic [7:0] b;
    int phase, cyc;
    bit first;
    while (bits_q.size() % 8 != 0) bits_q.push_back(1'b0);
    predict(n_rx);
    drive_q.delete();
    for (int n = 0; n < bits_q.size() / 8; n++) begin
      for (int i = 0; i < 8; i++) b[i] = bits_q[8*n+i];
      drive_q.push_back(b);
    end
    phase = 0;
    cyc   = 0;
    first = 1'b1;
    wait_for_sync = 1'b1;
    while (phase < 3) begin
      @(posedge byte_clock); #1;
      deser_in = (drive_q.size() > 0) ? drive_q.pop_front() : 8'h00;
      @(negedge byte_clock);
      case (phase)
        0: begin
          if (sync_found) begin
            chk("sync_offset", sync_offset, exp_off);
            chk("vld_at_sync", data_vld, 0);
`ifdef CSI_ALIGN_SOT_ERR_TOL_EN
            chk("sync_err", sync_err, exp_err);
`endif
            wait_for_sync = (mode == 1);
            phase = 1;
          end else begin
            cyc++;
            if (cyc > 40) begin
              chk("sync_wait", 0, 1);
              phase = 3;
            end
          end
        end
        1: begin
          if (first) chk("found_pulse", sync_found, 0);
          first = 1'b0;
          chk("data_vld", data_vld, 1);
          chk("data_out", data_out, exp_q.pop_front());
          if (exp_q.size() == 0) begin
            chk("offset_hold", sync_offset, exp_off);
            if (mode == 2) phase = 3;
            else begin
              packet_done = 1'b1;
              phase = 2;
            end
          end
        end
        default: begin
          chk("vld_drop", data_vld, 0);
          chk("state_after_done", state_dbg, (mode == 1) ? DBG_HUNT : DBG_IDLE);
          packet_done = 1'b0;
          phase = 3;
        end
      endcase
    end
  endtask

  task automatic quiet_cycles(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(posedge byte_clock); #1;
      deser_in = 8'h00;
      @(negedge byte_clock);
      if (data_vld || sync_found) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    int k;
    int early;
    reset_n       = 1'b0;
    enable        = 1'b0;
    wait_for_sync = 1'b0;
    packet_done   = 1'b0;
    deser_in      = 8'h00;
    repeat (3) @(posedge byte_clock);
    @(negedge byte_clock);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_data_vld", data_vld, 0);
    chk("rst_sync_found", sync_found, 0);
    chk("rst_sync_offset", sync_offset, 0);
    chk("rst_sync_timeout", sync_timeout, 0);
    chk("rst_state", state_dbg, DBG_IDLE);
    reset_n = 1'b1;
    enable  = 1'b1;

    // offset sweep
    for (int kk = 0; kk < 8; kk++) begin
      idle(3);
      bits_q.delete();
      push_zeros(32 + kk);
      push_bits(SYNC, 8);
      push_bits(8'h11, 8); push_bits(8'h22, 8); push_bits(8'h33, 8);
      push_zeros(16);
      run_packet(3, 0);
    end

    // packet_done after second byte, rearm, second packet at offset 5
    idle(3);
    bits_q.delete();
    push_zeros(35); push_bits(SYNC, 8);
    push_bits(8'h11, 8); push_bits(8'h22, 8); push_bits(8'h33, 8);
    push_zeros(16);
    run_packet(2, 1);
    bits_q.delete();
    push_zeros(37); push_bits(SYNC, 8);
    push_bits(8'h44, 8); push_bits(8'h55, 8);
    push_zeros(16);
    run_packet(2, 0);

    // hunt timeout on an all-zero stream
    idle(3);
    @(posedge byte_clock); #1;
    wait_for_sync = 1'b1;
    @(posedge byte_clock); #1;
    wait_for_sync = 1'b0;
    early = 0;
    for (int j = 1; j <= TIMEOUT; j++) begin
      @(posedge byte_clock);
      @(negedge byte_clock);
      if (j < TIMEOUT && (sync_timeout || state_dbg != DBG_HUNT)) early++;
    end
    chk("timeout_early", early, 0);
    chk("timeout_pulse", sync_timeout, 1);
    chk("timeout_state", state_dbg, DBG_IDLE);
    chk("timeout_vld", data_vld, 0);
    @(posedge byte_clock);
    @(negedge byte_clock);
    chk("timeout_pulse_end", sync_timeout, 0);
    chk("timeout_stay_idle", state_dbg, DBG_IDLE);

    // async reset mid-packet
    idle(3);
    bits_q.delete();
    push_zeros(36); push_bits(SYNC, 8);
    for (int i = 0; i < 4; i++) push_bits(8'($urandom_range(1, 255)), 8);
    push_zeros(16);
    run_packet(2, 2);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_vld", data_vld, 0);
    chk("arst_data_out", data_out, 8'h00);
    chk("arst_offset", sync_offset, 0);
    chk("arst_state", state_dbg, DBG_IDLE);
    @(negedge byte_clock);
    reset_n = 1'b1;
    quiet_cycles("quiet_after_reset", 8);

    // enable low mid-packet: data_out holds the last byte
    idle(3);
    bits_q.delete();
    push_zeros(38); push_bits(SYNC, 8);
    push_bits(8'h5A, 8); push_bits(8'hA5, 8); push_bits(8'h3C, 8); push_bits(8'hC3, 8);
    push_zeros(16);
    run_packet(2, 2);
    enable = 1'b0;
    @(posedge byte_clock);
    @(negedge byte_clock);
    chk("en_low_vld", data_vld, 0);
    chk("en_low_hold", data_out, 8'hA5);
    chk("en_low_state", state_dbg, DBG_IDLE);
    enable = 1'b1;
    quiet_cycles("quiet_after_enable", 8);
    idle(2);
    bits_q.delete();
    push_zeros(33); push_bits(SYNC, 8);
    push_bits(8'h77, 8); push_bits(8'h88, 8);
    push_zeros(16);
    run_packet(2, 0);

    // single-bit-error sync
    idle(3);
`ifdef CSI_ALIGN_SOT_ERR_TOL_EN
    bits_q.delete();
    push_zeros(34); push_bits(8'hB9, 8);
    push_bits(8'h12, 8); push_bits(8'h34, 8);
    push_zeros(16);
    run_packet(2, 0);
    idle(3);
    bits_q.delete();
    push_zeros(32); push_bits(8'b0011_1000, 6); push_bits(SYNC, 8);
    push_bits(8'h9A, 8); push_bits(8'hBC, 8);
    push_zeros(16);
    run_packet(2, 0);
`else
    bits_q.delete();
    push_zeros(34); push_bits(8'hB9, 8);
    push_bits(8'h12, 8); push_bits(8'h34, 8);
    push_zeros(16);
    while (bits_q.size() % 8 != 0) bits_q.push_back(1'b0);
    begin
      logic [7:0] b;
      int locks;
      locks = 0;
      wait_for_sync = 1'b1;
      for (int n = 0; n < 20; n++) begin
        for (int i = 0; i < 8; i++) b[i] = (8*n+i < bits_q.size()) ? bits_q[8*n+i] : 1'b0;
        @(posedge byte_clock); #1;
        deser_in = b;
        @(negedge byte_clock);
        if (sync_found || data_vld) locks++;
      end
      chk("b9_no_lock", locks, 0);
    end
`endif

    // long random payload at a random offset
    idle(3);
    k = $urandom_range(0, 7);
    bits_q.delete();
    push_zeros(32 + k); push_bits(SYNC, 8);
    for (int i = 0; i < 200; i++) push_bits(8'($urandom_range(0, 255)), 8);
    push_zeros(16);
    run_packet(200, 0);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
